// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone B3 types for the burst-capable BRAM slave:
//               cycle-type and burst-type encodings, the read FSM state
//               type, and the wrap-window helper used by the burst
//               address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Cycle type identifier (CTI).
    // The reserved codes 011..110 have no name and are handled as classic.
    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_t;

    // Burst type extension (BTE)
    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_t;

    // Read FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FIRST  = 2'b01,
        ST_STREAM = 2'b10
    } rd_state_t;

    // Selects the low index bits that take part in a wrapping increment.
    // LINEAR returns 0; the caller treats that value as "no wrap window".
    function automatic logic [3:0] wrap_mask(input bte_t bte);
        logic [3:0] m;
        m = 4'h0;
        case (bte)
            WRAP4:   m = 4'h3;
            WRAP8:   m = 4'h7;
            WRAP16:  m = 4'hF;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_bram_burst_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_burst_if
// Description : Wishbone B3 bus bundle carrying the signals of one
//               master/slave link with burst extensions.
//   Signals   : cyc, stb, we, adr[ADR_WIDTH], sel[DATA_WIDTH/8], cti[3],
//               bte[2], dat_ms[DATA_WIDTH] (master -> slave),
//               dat_sm[DATA_WIDTH], ack, err (slave -> master)
//   Modports  : master, slave
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_bram_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_WIDTH-1:0]    adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic [DATA_WIDTH-1:0]   dat_ms;
    logic [DATA_WIDTH-1:0]   dat_sm;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack, err
    );
endinterface : wb_bram_burst_if
`default_nettype wire

// File: rtl/wb_burst_adr_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_adr_gen
// Description : Combinational next-word-index generator for Wishbone
//               incrementing bursts. LINEAR wraps modulo the memory depth;
//               WRAP4/8/16 increment only the low 2/3/4 index bits.
//   Ports     : idx [MEM_ADR_WIDTH] in  - current word index
//               bte [2]             in  - burst type extension
//               nxt [MEM_ADR_WIDTH] out - next word index
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_adr_gen
    import wb_pkg::*;
#(
    parameter int MEM_ADR_WIDTH = 11
) (
    input  logic [MEM_ADR_WIDTH-1:0] idx,
    input  bte_t                     bte,
    output logic [MEM_ADR_WIDTH-1:0] nxt
);
    logic [MEM_ADR_WIDTH-1:0] w_inc;
    logic [MEM_ADR_WIDTH-1:0] w_mask;

    assign w_inc = idx + MEM_ADR_WIDTH'(1);

    // Bits inside the mask come from the increment; bits outside it are
    // held. A LINEAR burst uses an all-ones mask, so the whole index
    // increments and rolls over at the top of memory.
    always_comb begin
        w_mask = MEM_ADR_WIDTH'(wrap_mask(bte));
        if (bte == LINEAR) begin
            w_mask = '1;
        end
        nxt = (idx & ~w_mask) | (w_inc & w_mask);
    end
endmodule : wb_burst_adr_gen
`default_nettype wire

// File: rtl/wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_burst
// Description : Parametrised Wishbone B3 block-RAM slave. Supports classic,
//               constant-address and incrementing bursts (linear and
//               wrap-4/8/16). Writes are acknowledged with zero wait states.
//               Reads take one wait state on the first beat and then stream
//               at one beat per cycle.
//   Ports     : clk    in  - system clock
//               rst_n  in  - asynchronous active-low reset
//               wb     slave modport of wb_bram_burst_if
//   Option    : WB_BRAM_ERR_EN - when defined, any set address bit above the
//               memory window raises wb.err in place of wb.ack, and a write
//               to such an address is suppressed. When undefined, the upper
//               address bits alias and wb.err is held at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_burst
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADR_WIDTH = 11,
    parameter int ADR_WIDTH     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_bram_burst_if.slave wb
);
    localparam int c_NBYTES = DATA_WIDTH / 8;
    localparam int c_LSB    = $clog2(c_NBYTES);
    localparam int c_DEPTH  = 1 << MEM_ADR_WIDTH;

    logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];
    rd_state_t                r_state;
    rd_state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0]    r_dat;
    logic [MEM_ADR_WIDTH-1:0] r_pred;       // index of the word held in r_dat
    logic [MEM_ADR_WIDTH-1:0] w_idx;
    logic [MEM_ADR_WIDTH-1:0] w_idx_nxt;
    logic [MEM_ADR_WIDTH-1:0] w_rd_idx;
    logic                     w_req;
    logic                     w_addr_ok;
    logic                     w_oor;
    logic                     w_rd_en;
    logic                     w_wr_en;
    logic                     w_ack;
    logic                     w_err;
    logic                     w_unused;

    assign w_req     = wb.cyc & wb.stb;
    assign w_idx     = wb.adr[MEM_ADR_WIDTH+c_LSB-1 -: MEM_ADR_WIDTH];
    assign w_addr_ok = (w_idx == r_pred);

    // Byte-lane bits and, without range checking, the upper bits are
    // don't-cares.
    assign w_unused  = ^wb.adr;

`ifdef WB_BRAM_ERR_EN
    if (ADR_WIDTH > MEM_ADR_WIDTH + c_LSB) begin : g_oor
        assign w_oor = |wb.adr[ADR_WIDTH-1:MEM_ADR_WIDTH+c_LSB];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end
`else
    assign w_oor = 1'b0;
`endif

    wb_burst_adr_gen #(
        .MEM_ADR_WIDTH (MEM_ADR_WIDTH)
    ) u_adr_gen (
        .idx (w_idx),
        .bte (bte_t'(wb.bte)),
        .nxt (w_idx_nxt)
    );

    // Next state and bus responses
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_idx    = w_idx;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_wr_en     = 1'b0;

        if (w_req && wb.we) begin
            // Writes win in every state. Returning to IDLE discards any
            // prefetched word, which could now be stale.
            w_state_nxt = ST_IDLE;
            if (w_oor) begin
                w_err = 1'b1;
            end else begin
                w_ack   = 1'b1;
                w_wr_en = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        w_rd_en     = 1'b1;
                        w_state_nxt = ST_FIRST;
                    end
                end
                ST_FIRST, ST_STREAM: begin
                    if (!w_req) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!w_addr_ok) begin
                        // The master went somewhere other than the
                        // prefetched word: fetch the word it asked for.
                        w_rd_en     = 1'b1;
                        w_state_nxt = ST_FIRST;
                    end else if (w_oor) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ack = 1'b1;
                        if (wb.cti == CONST) begin
                            w_rd_en     = 1'b1;
                            w_rd_idx    = w_idx;
                            w_state_nxt = ST_STREAM;
                        end else if (wb.cti == INCR) begin
                            w_rd_en     = 1'b1;
                            w_rd_idx    = w_idx_nxt;
                            w_state_nxt = ST_STREAM;
                        end else begin
                            // CLASSIC, EOB and the reserved codes all end
                            // here, so the ack lasts a single cycle.
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // The write ack has no registered term, so it is masked while reset is
    // held to keep both bus responses at 0 during reset.
    assign wb.ack    = w_ack & rst_n;
    assign wb.err    = w_err & rst_n;
    assign wb.dat_sm = r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dat   <= '0;
            r_pred  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_en) begin
                r_dat  <= r_mem[w_rd_idx];
                r_pred <= w_rd_idx;
            end
        end
    end

    // RAM array, not reset
    always_ff @(posedge clk) begin
        if (w_wr_en && rst_n) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (wb.sel[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= wb.dat_ms[i*8 +: 8];
                end
            end
        end
    end
endmodule : wb_bram_burst
`default_nettype wire

// File: tb/tb_wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bram_burst
// Description : Self-checking bench for wb_bram_burst. Stimulus tasks push
//               the expected response of every beat into a scoreboard
//               queue. A monitor pops the queue on each ack and compares the
//               data. Wait-state counts are predicted from the bus protocol
//               rules, and read data comes from a word-array memory model.
//               Directed scenarios are followed by randomized bursts.
//               The WB_BRAM_ERR_EN macro enables the error-response checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bram_burst;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int MAW   = 11;
    localparam int DEPTH = 1 << MAW;

    localparam logic [2:0] T_CLASSIC = 3'b000;
    localparam logic [2:0] T_CONST   = 3'b001;
    localparam logic [2:0] T_INCR    = 3'b010;
    localparam logic [2:0] T_EOB     = 3'b111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_bram_burst_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

    wb_bram_burst #(
        .DATA_WIDTH    (DW),
        .MEM_ADR_WIDTH (MAW),
        .ADR_WIDTH     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq [$];
    exp_t        mon_e;
    logic [31:0] ref_mem [DEPTH];
    int          n_chk = 0;
    int          n_err = 0;
    bit          pred_valid = 0;
    int          pred_idx   = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Next word index of an incrementing burst, from the burst-type rules
    function automatic int next_idx(input int idx, input int bte);
        int sz;
        if (bte == 0) return (idx + 1) % DEPTH;
        sz = 2 << bte;
        return (idx / sz) * sz + (idx + 1) % sz;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.ack) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.we) check("ack_is_write", bus.we, 1);
                else          check("read_data", bus.dat_sm, mon_e.data);
            end
        end
    end

    task automatic drive_beat(input logic we, input logic [31:0] adr,
                              input logic [3:0] sel, input logic [31:0] dat,
                              input logic [2:0] cti, input logic [1:0] bte,
                              output int waits);
        bit done;
        int idx;
        idx        = int'(adr[MAW+1:2]);
        bus.cyc    = 1'b1;
        bus.stb    = 1'b1;
        bus.we     = we;
        bus.adr    = adr;
        bus.sel    = sel;
        bus.dat_ms = dat;
        bus.cti    = cti;
        bus.bte    = bte;
        sbq.push_back('{we: we, data: (we ? 32'h0 : ref_mem[idx])});
        waits = 0;
        done  = 0;
        forever begin
            @(negedge clk);
            if (bus.ack) done = 1;
            @(posedge clk);
            #1;
            if (done) break;
            waits++;
            if (waits > 16) begin
                check("beat_timeout", 0, 1);
                void'(sbq.pop_back());
                break;
            end
        end
        if (done && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][b*8 +: 8] = dat[b*8 +: 8];
        end
    endtask

    // One beat, with the expected wait-state count taken from the protocol
    task automatic beat(input logic we, input int idx, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [2:0] cti,
                        input logic [1:0] bte);
        int w;
        int expw;
        expw = (we || (pred_valid && idx == pred_idx)) ? 0 : 1;
        drive_beat(we, 32'(idx) << 2, sel, dat, cti, bte, w);
        check("wait_states", w, expw);
        if (we) begin
            pred_valid = 0;
        end else if (cti == T_INCR) begin
            pred_valid = 1;
            pred_idx   = next_idx(idx, int'(bte));
        end else if (cti == T_CONST) begin
            pred_valid = 1;
            pred_idx   = idx;
        end else begin
            pred_valid = 0;
        end
    endtask

    task automatic idle(input int n);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        if (n > 0) pred_valid = 0;
    endtask

    // Keep the last request on the bus one more cycle: no ack is allowed
    task automatic hold_no_ack(input string name);
        @(negedge clk);
        check(name, bus.ack, 0);
        @(posedge clk);
        #1;
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int idx;
        int bte;
        logic [2:0] cti_mid;

        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = 0; bus.sel = 0;
        bus.cti = 0; bus.bte = 0; bus.dat_ms = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dat", bus.dat_sm, 0);
        check("reset_ack", bus.ack, 0);
        check("reset_err", bus.err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Words 0..63 hold their own index
        for (int i = 0; i < 64; i++) beat(1, i, 4'hF, 32'(i), T_CLASSIC, 2'b00);
        idle(1);

        // Incrementing linear burst over words 0..3
        for (int i = 0; i < 4; i++) beat(0, i, 4'hF, 0, (i == 3) ? T_EOB : T_INCR, 2'b00);
        hold_no_ack("incr_ack_after_eob");

        // Wrap-4 burst from word 6: indices 6, 7, 4, 5
        idx = 6;
        for (int i = 0; i < 4; i++) begin
            beat(0, idx, 4'hF, 0, (i == 3) ? T_EOB : T_INCR, 2'b01);
            idx = next_idx(idx, 1);
        end
        check("wrap4_last_data", bus.dat_sm, 5);
        hold_no_ack("wrap4_ack_after_eob");

        // Master wait state of two cycles in the middle of a burst
        beat(0, 12, 4'hF, 0, T_INCR, 2'b00);
        beat(0, 13, 4'hF, 0, T_INCR, 2'b00);
        bus.stb = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stb_low_no_ack", bus.ack, 0);
            @(posedge clk);
            #1;
        end
        pred_valid = 0;
        beat(0, 14, 4'hF, 0, T_INCR, 2'b00);
        beat(0, 15, 4'hF, 0, T_EOB, 2'b00);
        idle(1);

        // Reset asserted during the second beat of a burst
        beat(0, 20, 4'hF, 0, T_INCR, 2'b00);
        bus.adr = 32'(21) << 2;
        sbq.push_back('{we: 1'b0, data: ref_mem[21]});
        @(negedge clk);
        check("rst_beat2_ack", bus.ack, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack_drop", bus.ack, 0);
        check("rst_dat_clear", bus.dat_sm, 0);
        bus.cyc = 0;
        bus.stb = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        beat(0, 21, 4'hF, 0, T_CLASSIC, 2'b00);
        idle(1);

        // Write then classic read at byte address 0x10
        beat(1, 4, 4'hF, 32'hDEADBEEF, T_CLASSIC, 2'b00);
        beat(0, 4, 4'hF, 0, T_CLASSIC, 2'b00);
        check("classic_data", bus.dat_sm, 32'hDEADBEEF);
        hold_no_ack("classic_ack_3rd_cycle");

        // Byte-enable merge at byte address 0x20
        beat(1, 8, 4'hF, 32'hAAAAAAAA, T_CLASSIC, 2'b00);
        beat(1, 8, 4'b0101, 32'h11223344, T_CLASSIC, 2'b00);
        beat(0, 8, 4'hF, 0, T_CLASSIC, 2'b00);
        check("sel_merge_data", bus.dat_sm, 32'hAA22AA44);
        idle(1);

`ifdef WB_BRAM_ERR_EN
        // Out-of-range read: err where the ack would be, for one cycle
        bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = 32'h0001_0000;
        bus.sel = 4'hF; bus.cti = T_CLASSIC; bus.bte = 0;
        @(negedge clk);
        check("oor_rd_first_err", bus.err, 0);
        check("oor_rd_first_ack", bus.ack, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("oor_rd_err", bus.err, 1);
        check("oor_rd_ack", bus.ack, 0);
        @(posedge clk);
        #1;
        idle(1);
        @(negedge clk);
        check("oor_err_cleared", bus.err, 0);
        // Out-of-range write aliasing word 0 must not modify it
        bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.adr = 32'h0001_0000;
        bus.dat_ms = 32'h55555555;
        @(negedge clk);
        check("oor_wr_err", bus.err, 1);
        check("oor_wr_ack", bus.ack, 0);
        @(posedge clk);
        #1;
        idle(1);
        beat(0, 0, 4'hF, 0, T_CLASSIC, 2'b00);
        idle(1);
`endif

        // Randomized bursts, jumps and interleaved writes
        for (int op = 0; op < 60; op++) begin
            if ($urandom_range(0, 3) == 0) begin
                beat(1, $urandom_range(0, 47), 4'($urandom), $urandom, T_CLASSIC, 2'b00);
            end else begin
                len     = $urandom_range(1, 8);
                bte     = $urandom_range(0, 3);
                cti_mid = ($urandom_range(0, 1) == 1) ? T_INCR : T_CONST;
                idx     = $urandom_range(0, 47);
                for (int b = 0; b < len; b++) begin
                    if (b > 0) begin
                        if ($urandom_range(0, 4) == 0) idx = $urandom_range(0, 47);
                        else if (cti_mid == T_INCR)    idx = next_idx(idx, bte);
                    end
                    if ($urandom_range(0, 7) == 0) begin
                        beat(1, idx, 4'($urandom), $urandom, T_CLASSIC, 2'b00);
                    end else begin
                        beat(0, idx, 4'hF, 0,
                             (b == len - 1) ? (($urandom_range(0, 1) == 1) ? T_EOB : T_CLASSIC)
                                            : cti_mid,
                             2'(bte));
                    end
                end
            end
            idle($urandom_range(0, 2));
        end

        idle(2);
        check("scoreboard_drained", 64'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule : tb_wb_bram_burst
`default_nettype wire
